// File: rtl/example_mul_arb_pkg.sv
// Shared constants and the pipeline stage record for example_mul_arb.
// Operand a is unsigned 8-bit, operand b is signed 14-bit, and the product
// is kept as the low 21 bits.
package example_mul_arb_pkg;

    localparam int A_W      = 8;
    localparam int B_W      = 14;
    localparam int P_W      = 21;
    // Widest requester tag needed for the supported range (N_REQ up to 8).
    localparam int ID_MAX_W = 3;

    // One pipeline stage: occupancy flag, product and owning requester.
    typedef struct packed {
        logic                valid;
        logic [P_W-1:0]      p;
        logic [ID_MAX_W-1:0] id;
    } stage_t;

endpackage

// File: rtl/example_mul_arb_dsp.sv
// Combinational multiply: unsigned a times signed b, truncated to P_W bits.
// Both operands are widened to P_W before multiplying, so the result is the
// low P_W bits of the full product. It wraps silently and never saturates.
module example_mul_arb_dsp
    import example_mul_arb_pkg::*;
(
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [P_W-1:0] p
);

    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;

    // a is zero-extended because it is unsigned; b is sign-extended.
    assign a_ext = {{(P_W-A_W){1'b0}}, a};
    assign b_ext = {{(P_W-B_W){b[B_W-1]}}, b};
    assign p     = a_ext * b_ext;

endmodule

// File: rtl/example_mul_arb.sv
// Round-robin arbiter that shares one multiplier among N_REQ requesters.
// The default build has one register stage, giving a latency of 1.
// Defining EXAMPLE_MUL_ARB_PIPE_EN adds a second register stage after the
// multiply, giving a latency of 2. The two stages use global-stall flow
// control, and an empty stage 1 is refilled even while stage 2 is stalled.
module example_mul_arb
    import example_mul_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*A_W-1:0] req_a,
    input  logic [N_REQ*B_W-1:0] req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [P_W-1:0]       res_p,
    output logic [ID_W-1:0]      res_id
);

    logic [ID_W-1:0] last_grant_reg;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic [ID_W:0]   cand;
    logic            accept;
    logic            transfer;
    logic [A_W-1:0]  a_arr [N_REQ];
    logic [B_W-1:0]  b_arr [N_REQ];
    logic [P_W-1:0]  prod;
    stage_t          new_stage;
    stage_t          out_stage;
    logic            id_hi_unused;

    // Unpack the flat operand buses into per-requester lanes and form the
    // one-hot ready vector.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign a_arr[gi]     = req_a[gi*A_W +: A_W];
            assign b_arr[gi]     = req_b[gi*B_W +: B_W];
            assign req_ready[gi] = accept && grant_found && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Round-robin search: start at last_grant+1 and wrap modulo N_REQ.
    // The first requester found with valid set wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_grant_reg} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign transfer = |req_ready;

    example_mul_arb_dsp u_dsp (
        .a (a_arr[grant_idx]),
        .b (b_arr[grant_idx]),
        .p (prod)
    );

    // Build the record for the operand pair being accepted this cycle.
    always_comb begin
        new_stage       = '0;
        new_stage.valid = 1'b1;
        new_stage.p     = prod;
        new_stage.id    = ID_MAX_W'(grant_idx);
    end

    // The pointer moves only on a real transfer. A requester that drops
    // valid before it is granted keeps its place in the rotation.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            last_grant_reg <= ID_W'(N_REQ-1);
        end else if (transfer) begin
            last_grant_reg <= grant_idx;
        end
    end

`ifdef EXAMPLE_MUL_ARB_PIPE_EN
    stage_t s1_reg;
    stage_t s2_reg;
    logic   advance;

    assign advance = !s2_reg.valid || res_ready;
    assign accept  = !ap_rst && (!s1_reg.valid || advance);

    // Stage 1 loads new products. It empties when it hands its product to
    // stage 2 and no new operand arrives.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_reg <= '0;
        end else if (transfer) begin
            s1_reg <= new_stage;
        end else if (advance) begin
            s1_reg.valid <= 1'b0;
        end
    end

    // Stage 2 drives the output and holds while the consumer stalls.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s2_reg <= '0;
        end else if (advance) begin
            s2_reg <= s1_reg;
        end
    end

    assign out_stage = s2_reg;
`else
    stage_t out_reg;

    assign accept = !ap_rst && (!out_reg.valid || res_ready);

    // A single output stage. If a new product arrives on the same edge that
    // the consumer takes the old one, it replaces it with no bubble.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            out_reg <= '0;
        end else if (transfer) begin
            out_reg <= new_stage;
        end else if (res_ready) begin
            out_reg.valid <= 1'b0;
        end
    end

    assign out_stage = out_reg;
`endif

    assign res_valid = out_stage.valid;
    assign res_p     = out_stage.p;
    assign res_id    = out_stage.id[ID_W-1:0];
    // Tag bits above ID_W are always written as zero.
    assign id_hi_unused = ^out_stage.id;

endmodule

// File: tb/tb_example_mul_arb.sv
// Self-checking bench for example_mul_arb (N_REQ=4).
// Arbitration order is checked against a table of {valid, res_ready, expected ready}.
// Products and tags are checked by a scoreboard queue: entries are pushed on
// each transfer and popped on each output handshake.
module tb_example_mul_arb;

`ifdef EXAMPLE_MUL_ARB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [55:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [20:0] res_p;
    logic [1:0]  res_id;

    logic [7:0]  op_a [4];
    logic [13:0] op_b [4];

    typedef struct {
        logic [3:0] valid;
        logic       rdy;
        logic [3:0] exp_ready;
    } vec_t;
    vec_t vecs [16];

    typedef struct {
        logic [20:0] p;
        logic [1:0]  id;
    } sb_t;
    sb_t exp_q [$];

    int n_vec = 0;
    int n_err = 0;

    logic        hold_chk = 1'b0;
    logic [23:0] hold_prev;

    example_mul_arb #(.N_REQ(4), .ID_W(2)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_p     (res_p),
        .res_id    (res_id)
    );

    always #5 ap_clk = ~ap_clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8]   = op_a[i];
            req_b[i*14 +: 14] = op_b[i];
        end
    end

    function automatic logic [20:0] model(logic [7:0] a, logic [13:0] b);
        int          ai;
        int          bi;
        int          pr;
        logic [31:0] t;
        ai = int'(a);
        bi = int'($signed(b));
        pr = ai * bi;
        t  = pr;
        return t[20:0];
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Monitor: checks the output hold, pops on each handshake, then pushes
    // the expected product for any transfer happening at the next edge.
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            exp_q.delete();
            hold_chk = 1'b0;
        end else begin
            sb_t e;
            if (hold_chk) begin
                check("hold", {8'h0, res_valid, res_p, res_id}, {8'h0, hold_prev});
            end
            check("onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got p=%0h id=%0d expected no result", res_p, res_id);
                end else begin
                    e = exp_q.pop_front();
                    $display("result p=%0h id=%0d (expected p=%0h id=%0d)", res_p, res_id, e.p, e.id);
                    check("sb_p", 32'(res_p), 32'(e.p));
                    check("sb_id", 32'(res_id), 32'(e.id));
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.p  = model(req_a[i*8 +: 8], req_b[i*14 +: 14]);
                    e.id = 2'(i);
                    exp_q.push_back(e);
                end
            end
            hold_chk  = res_valid && !res_ready;
            hold_prev = {res_valid, res_p, res_id};
        end
    end

    initial begin
        ap_rst    = 1'b1;
        req_valid = 4'hF;
        res_ready = 1'b1;
        op_a[0] = 8'd10;  op_b[0] = 14'd100;
        op_a[1] = 8'd20;  op_b[1] = 14'd200;
        op_a[2] = 8'd200; op_b[2] = 14'h2000;
        op_a[3] = 8'd77;  op_b[3] = 14'd1234;

        vecs[0]  = '{4'b1111, 1'b1, 4'b0100};
        vecs[1]  = '{4'b1111, 1'b1, 4'b1000};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0001};
        vecs[3]  = '{4'b1111, 1'b1, 4'b0010};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0100};
        vecs[5]  = '{4'b1111, 1'b1, 4'b1000};
        vecs[6]  = '{4'b1111, 1'b1, 4'b0001};
        vecs[7]  = '{4'b0011, 1'b0, 4'b0000};
        vecs[8]  = '{4'b0011, 1'b0, 4'b0000};
        vecs[9]  = '{4'b0011, 1'b1, 4'b0010};
        vecs[10] = '{4'b1100, 1'b0, 4'b0000};
        vecs[11] = '{4'b1000, 1'b1, 4'b1000};
        vecs[12] = '{4'b0101, 1'b1, 4'b0001};
        vecs[13] = '{4'b0101, 1'b1, 4'b0100};
        vecs[14] = '{4'b0000, 1'b1, 4'b0000};
        vecs[15] = '{4'b0000, 1'b1, 4'b0000};

        // Reset: no ready while reset is held, then the outputs are cleared.
        repeat (2) step();
        @(negedge ap_clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        step();
        ap_rst    = 1'b0;
        req_valid = 4'h0;
        @(negedge ap_clk);
        check("rst_valid", 32'(res_valid), 32'h0);
        check("rst_p", 32'(res_p), 32'h0);
        check("rst_id", 32'(res_id), 32'h0);
        step();

        // Single requester: 3 * -5.
        op_a[0]   = 8'd3;
        op_b[0]   = 14'h3FFB;
        req_valid = 4'b0001;
        @(negedge ap_clk);
        check("t1_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        repeat (LAT-1) step();
        @(negedge ap_clk);
        check("t1_valid", 32'(res_valid), 32'h1);
        check("t1_p", 32'(res_p), 32'h1FFFF1);
        check("t1_id", 32'(res_id), 32'h0);
        step();

        // Truncation: 255 * 8191.
        op_a[1]   = 8'd255;
        op_b[1]   = 14'd8191;
        req_valid = 4'b0010;
        @(negedge ap_clk);
        check("t2_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0000;
        repeat (LAT-1) step();
        @(negedge ap_clk);
        check("t2_valid", 32'(res_valid), 32'h1);
        check("t2_p", 32'(res_p), 32'h1FDF01);
        check("t2_id", 32'(res_id), 32'h1);
        step();

        // Round-robin, stalls and dropped requests, all from the table.
        for (int v = 0; v < 16; v++) begin
            req_valid = vecs[v].valid;
            res_ready = vecs[v].rdy;
            @(negedge ap_clk);
            $display("vec %0d valid=%b rdy=%b ready=%b (expected %b)", v, vecs[v].valid, vecs[v].rdy, req_ready, vecs[v].exp_ready);
            check($sformatf("rr[%0d]", v), 32'(req_ready), 32'(vecs[v].exp_ready));
            step();
        end

        // Backpressure: hold the output for 5 cycles, then release it.
        res_ready = 1'b1;
        req_valid = 4'b0001;
        @(negedge ap_clk);
        check("bp_first", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0000;
        res_ready = 1'b0;
        repeat (LAT-1) step();
`ifdef EXAMPLE_MUL_ARB_PIPE_EN
        req_valid = 4'b0010;
        @(negedge ap_clk);
        check("bubble_refill", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0100;
        repeat (4) begin
            @(negedge ap_clk);
            check("bp_stall", 32'(req_ready), 32'h0);
            check("bp_hold_valid", 32'(res_valid), 32'h1);
            step();
        end
        res_ready = 1'b1;
        @(negedge ap_clk);
        check("bp_release", 32'(req_ready), 32'h4);
        step();
`else
        req_valid = 4'b0010;
        repeat (5) begin
            @(negedge ap_clk);
            check("bp_stall", 32'(req_ready), 32'h0);
            check("bp_hold_valid", 32'(res_valid), 32'h1);
            step();
        end
        res_ready = 1'b1;
        @(negedge ap_clk);
        check("bp_release", 32'(req_ready), 32'h2);
        step();
`endif
        req_valid = 4'b0000;
        repeat (LAT+1) step();

        // Reset mid-stream: discard in-flight results; requester 0 is first after reset.
        req_valid = 4'hF;
        res_ready = 1'b1;
        repeat (3) step();
        ap_rst = 1'b1;
        @(negedge ap_clk);
        check("rst_mid_busy", 32'(res_valid), 32'h1);
        check("rst_mid_ready", 32'(req_ready), 32'h0);
        step();
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("rst_mid_valid", 32'(res_valid), 32'h0);
        check("rst_first_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'h0;
        repeat (LAT+2) step();
        @(negedge ap_clk);
        check("sb_empty", 32'(exp_q.size()), 32'h0);
        check("idle_valid", 32'(res_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
